qspi_read_master: RTL and testbench
===================================

Name: qspi_read_master

Overview:
- Synthesizable, parametrised successor to the single-mode QSPI read master.
- Accepts burst-read requests over a req/ack handshake and issues one of three flash commands:
  - READ 0x03
  - FAST_READ 0x0B
  - Quad Output Fast Read 0x6B
- Streams received bytes out with a valid strobe.
- Sits between the sdram/usb loader logic and the external flash pins. Generates spi_sck at qspi_clk/2.

Parameters:
- ADDR_W, 24: flash address width in bits, sent MSB first, 8..32.
- DUMMY_CYC, 8: dummy SCK cycles for 0x0B/0x6B, 0..15.
- BL_W, 4: burst length field width. Burst bytes = req_len+1, so 1..2^BL_W.

Ports:
- qspi_clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  level request; sampled only in IDLE.
- req_addr  in  ADDR_W  start address.
- req_len  in  BL_W  bytes minus one.
- req_fast  in  1  1 = FAST_READ with dummy; 0 = READ.
- req_quad  in  1  1 = quad data phase (0x6B); overrides req_fast.
- ack  out  1  one-cycle pulse: request captured.
- busy  out  1  high from ack cycle through done cycle.
- done  out  1  one-cycle pulse after csn deasserts.
- rd_data  out  8  received byte, MSB first.
- rd_valid  out  1  one-cycle strobe qualifying rd_data.
- spi_sck  out  1  SPI clock, mode 0, idles low.
- spi_csn  out  1  chip select, active low.
- io_out  out  4  pad output data; io[0]=DI, io[1]=DO, io[2]=WP#, io[3]=HOLD#.
- io_oe  out  4  pad output enables.
- io_in  in  4  pad input data.

Behaviour:
- Reset values:
  - spi_csn=1, spi_sck=0, ack=0, busy=0, done=0, rd_valid=0, rd_data=0.
  - io_out=4'b1100, io_oe=4'b1101.
  - FSM=IDLE, all counters 0.
- Reset asserted mid-transfer aborts immediately to these values; no done pulse is generated.
- Handshake:
  - In IDLE with req=1: ack=1 for that cycle, and addr/len/mode are registered.
  - req is ignored while busy.
- Command byte: req_quad ? 0x6B : req_fast ? 0x0B : 0x03.
- SCK timing:
  - Each SCK period is 2 qspi_clk cycles: low phase, then high phase.
  - The master changes io_out while sck is low.
  - The master samples io_in on the qspi_clk edge that drives sck 0->1.
- FSM states:
  - IDLE -> SETUP on ack.
  - SETUP: 1 cycle, csn=0, sck=0.
  - CMD: 8 SCK on io[0].
  - ADDR: ADDR_W SCK on io[0].
  - From ADDR, go to DUMMY if fast or quad and DUMMY_CYC!=0, else go to DATA.
  - DUMMY: DUMMY_CYC SCK. During DUMMY, io_oe[0]=0, and io_oe[3:2] are also 0 when quad.
  - DATA:
    - Single mode: 8 SCK per byte, sampling io_in[1].
    - Quad mode: 2 SCK per byte, sampling io_in[3:0] (high nibble first), with io_oe=0.
  - HOLD: sck=0 for 1 cycle, then csn=1 for 2 cycles. done pulses on the 2nd cycle, then the FSM returns to IDLE.
- Pin defaults outside quad phases: io[2], io[3] are driven 1 (WP#/HOLD# inactive); io_oe[1]=0 always.
- Data output:
  - rd_valid pulses the cycle after the last bit/nibble of each byte is sampled.
  - Exactly req_len+1 strobes are produced per burst.
  - A byte counter of width BL_W counts up and terminates the burst at req_len, so there is no wrap-around issue.
- Address is not auto-incremented: each request carries its own address. A subsequent req can be acked no earlier than the cycle after done.
- Latency, single READ, ADDR_W=24: ack to first rd_valid = 1+16+48+16+1 = 82 cycles.

Optional Feature:
- QSPI_QUAD_EN defined:
  - req_quad is honoured: 0x6B command, quad dummy/data phases, io_oe[3:2] released.
- QSPI_QUAD_EN undefined:
  - req_quad is treated as 0; quad datapath and nibble logic are removed.
  - io_oe is constant 4'b1101 except io_oe[0] during DUMMY.

Test Plan:
- READ, addr=0x000010, len=0, model returns 0xA5 -> io[0] shifts 0x03 then 0x000010; one rd_valid with rd_data=0xA5 exactly 82 cycles after ack; done 3 cycles after the last sample; csn high.
- FAST_READ, DUMMY_CYC=8, len=3, model bytes 0x11,0x22,0x33,0x44 -> cmd 0x0B; 16 cycles of dummy with io_oe[0]=0; 4 strobes in order; busy drops after done.
- Quad (QSPI_QUAD_EN), len=1, model nibbles 0xD,0xE,0xA,0xD -> cmd 0x6B; rd_data 0xDE then 0xAD, 4 cycles apart; io_oe=0 during data.
- req held high continuously, back-to-back -> second ack exactly 1 cycle after the first done; requests never overlap; csn high for at least 2 cycles between bursts.
- rst_n pulsed low during ADDR -> all outputs return to reset values asynchronously; no done pulse; the next req completes normally.
- req_len=15 (max, BL_W=4) -> exactly 16 rd_valid pulses, then HOLD; no extra SCK edges after the last sample.

Source files
------------

// File: rtl/qspi_read_master.sv
// qspi_read_master: burst-read master for SPI/QSPI NOR flash.
// Issues READ (0x03), FAST_READ (0x0B) or Quad Output Fast Read (0x6B),
// then streams the received bytes out with a one-cycle valid strobe.
// spi_sck runs at qspi_clk/2 (mode 0): one low cycle, then one high cycle.
// Optional build macro: QSPI_QUAD_EN enables the quad (0x6B) datapath.
module qspi_read_master #(
  parameter int ADDR_W    = 24,
  parameter int DUMMY_CYC = 8,
  parameter int BL_W      = 4
) (
  input  logic              qspi_clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BL_W-1:0]   req_len,
  input  logic              req_fast,
  input  logic              req_quad,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              spi_sck,
  output logic              spi_csn,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD} state_t;

  localparam int CW = 6;  // wide enough for ADDR_W-1 (31) and DUMMY_CYC-1 (14)

  state_t            state_q, state_d;
  logic              sck_q, sck_d;
  logic              csn_q, csn_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              hold_q, hold_d;
  logic              fast_q, fast_d;
  logic              quad_q;
  logic [CW-1:0]     bit_q, bit_d;
  logic [BL_W-1:0]   byte_q, byte_d;
  logic [BL_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic [7:0]        rx_sampled;
  logic [CW-1:0]     last_data_bit;
  logic [7:0]        cmd_byte;
  logic              dummy_en;

`ifdef QSPI_QUAD_EN
  logic quad_d;

  // Quad mode flag, captured with the request
  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) quad_q <= 1'b0;
    else        quad_q <= quad_d;
  end

  assign rx_sampled    = quad_q ? {rx_q[3:0], io_in} : {rx_q[6:0], io_in[1]};
  assign last_data_bit = quad_q ? CW'(1) : CW'(7);
  assign cmd_byte      = req_quad ? 8'h6B : (req_fast ? 8'h0B : 8'h03);
`else
  logic unused_in;

  assign quad_q        = 1'b0;
  assign unused_in     = ^{req_quad, io_in[3:2], io_in[0]};
  assign rx_sampled    = {rx_q[6:0], io_in[1]};
  assign last_data_bit = CW'(7);
  assign cmd_byte      = req_fast ? 8'h0B : 8'h03;
`endif

  assign dummy_en = (fast_q || quad_q) && (DUMMY_CYC != 0);

  // ack is only combinational in IDLE; gated by rst_n so it stays low in reset
  assign ack      = (state_q == IDLE) && req && rst_n;
  assign busy     = ack || (state_q != IDLE);
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign spi_sck  = sck_q;
  assign spi_csn  = csn_q;

  // State and datapath registers
  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      hold_q     <= 1'b0;
      fast_q     <= 1'b0;
      bit_q      <= '0;
      byte_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      hold_q     <= hold_d;
      fast_q     <= fast_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state: sck rises on the sampling step, falls on the shift/advance step
  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    hold_d     = hold_q;
    fast_d     = fast_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    len_d      = len_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
`ifdef QSPI_QUAD_EN
    quad_d     = quad_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          csn_d   = 1'b0;
          addr_d  = req_addr;
          len_d   = req_len;
          fast_d  = req_fast;
`ifdef QSPI_QUAD_EN
          quad_d  = req_quad;
`endif
          tx_d    = ADDR_W'(cmd_byte) << (ADDR_W - 8);
          bit_d   = '0;
          byte_d  = '0;
          hold_d  = 1'b0;
        end
      end
      SETUP: state_d = CMD;
      CMD, ADDR, DUMMY, DATA: begin
        if (!sck_q) begin
          sck_d = 1'b1;
          if (state_q == DATA) rx_d = rx_sampled;
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q + 1'b1;
          tx_d  = tx_q << 1;
          if (state_q == CMD) begin
            if (bit_q == CW'(7)) begin
              state_d = ADDR;
              bit_d   = '0;
              tx_d    = addr_q;
            end
          end else if (state_q == ADDR) begin
            if (bit_q == CW'(ADDR_W - 1)) begin
              state_d = dummy_en ? DUMMY : DATA;
              bit_d   = '0;
            end
          end else if (state_q == DUMMY) begin
            if (bit_q == CW'(DUMMY_CYC - 1)) begin
              state_d = DATA;
              bit_d   = '0;
            end
          end else begin
            if (bit_q == last_data_bit) begin
              bit_d      = '0;
              rd_valid_d = 1'b1;
              rd_data_d  = rx_q;
              byte_d     = byte_q + 1'b1;
              if (byte_q == len_q) state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!hold_q) begin
          csn_d  = 1'b1;
          hold_d = 1'b1;
        end else if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
          hold_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad drive: DI carries cmd/addr, WP#/HOLD# parked high unless quad releases them
  always_comb begin
    io_out = 4'b1100;
    io_oe  = 4'b1101;
    if (state_q == SETUP || state_q == CMD || state_q == ADDR) io_out[0] = tx_q[ADDR_W-1];
    if (state_q == DUMMY) begin
      io_oe[0] = 1'b0;
      if (quad_q) io_oe[3:2] = 2'b00;
    end
    if (state_q == DATA && quad_q) io_oe = 4'b0000;
  end

endmodule

// File: tb/tb_qspi_read_master.sv
// Directed bench for qspi_read_master with a behavioural SPI flash model.
module tb_qspi_read_master;
  localparam int ADDR_W = 24;
  localparam int DUMMY_CYC = 8;
  localparam int BL_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [BL_W-1:0] req_len = '0;
  logic req_fast = 1'b0, req_quad = 1'b0;
  logic ack, busy, done, rd_valid, spi_sck, spi_csn;
  logic [7:0] rd_data;
  logic [3:0] io_out, io_oe;
  logic [3:0] io_in = 4'b0000;

  qspi_read_master #(.ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY_CYC), .BL_W(BL_W)) dut (
    .qspi_clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
    .req_fast(req_fast), .req_quad(req_quad), .ack(ack), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .spi_sck(spi_sck), .spi_csn(spi_csn),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in));

  always #5 clk = ~clk;

  int checks = 0, passes = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // Flash model: captures cmd+addr on rising sck, shifts data out on falling sck
  logic [7:0] mem [16];
  logic [31:0] cap = '0;
  int edges = 0, hdr = 32, sck_tot = 0;
  bit mquad = 0;
  always @(posedge spi_sck) begin
    sck_tot++;
    if (!spi_csn && edges < 8 + ADDR_W) cap = {cap[30:0], io_out[0]};
    edges++;
  end
  always @(posedge spi_csn) edges = 0;
  always @(negedge spi_sck) begin
    int k, b;
    if (!spi_csn && edges >= hdr) begin
      k = edges - hdr;
      if (mquad) begin
        b = k / 2;
        if (b < 16) io_in = (k % 2 == 0) ? mem[b][7:4] : mem[b][3:0];
      end else begin
        b = k / 8;
        if (b < 16) io_in = {2'b00, mem[b][7 - k % 8], 1'b0};
      end
    end
  end

  // Event logs sampled mid-cycle
  int acks[$], vc[$], dones[$];
  logic [7:0] vd[$];
  int oe0_lo = 0, oe_zero = 0, hi_run = 0, last_hi = 0;
  always @(negedge clk) begin
    if (ack) acks.push_back(cyc);
    if (rd_valid) begin vc.push_back(cyc); vd.push_back(rd_data); end
    if (done) dones.push_back(cyc);
    if (!spi_csn && !io_oe[0]) oe0_lo++;
    if (io_oe == 4'b0000) oe_zero++;
    if (spi_csn) hi_run++;
    else begin if (hi_run > 0) last_hi = hi_run; hi_run = 0; end
  end

  task automatic clear_logs();
    acks.delete(); vc.delete(); vd.delete(); dones.delete();
    oe0_lo = 0; oe_zero = 0; cap = '0; sck_tot = 0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [BL_W-1:0] l, input bit f, input bit q);
    int n0 = acks.size();
    int i = 0;
    @(posedge clk); #2;
    req_addr = a; req_len = l; req_fast = f; req_quad = q; req = 1'b1;
    while (acks.size() == n0 && i < 10) begin @(posedge clk); i++; end
    #2 req = 1'b0;
    checks++; if (acks.size() == n0) $display("FAIL ack_timeout: got no ack, required one"); else passes++;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int i = 0;
    while (dones.size() < n && i < budget) begin @(posedge clk); i++; end
    checks++; if (dones.size() < n) $display("FAIL done_timeout: got %0d dones, required %0d", dones.size(), n); else passes++;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({spi_csn, spi_sck, ack, busy, done, rd_valid} !== 6'b100000) $display("FAIL reset_ctl: got %b required 100000", {spi_csn, spi_sck, ack, busy, done, rd_valid}); else passes++;
    checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h required 00", rd_data); else passes++;
    checks++; if ({io_out, io_oe} !== 8'b1100_1101) $display("FAIL reset_io: got %b required 11001101", {io_out, io_oe}); else passes++;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_read();
    mem[0] = 8'hA5; hdr = 32; mquad = 0;
    clear_logs();
    issue(24'h000010, 4'd0, 1'b0, 1'b0);
    wait_dones(1, 200);
    checks++; if (cap !== 32'h03000010) $display("FAIL read_cmd_addr: got %h required 03000010", cap); else passes++;
    checks++; if (vc.size() != 1) $display("FAIL read_strobes: got %0d required 1", vc.size()); else passes++;
    checks++; if (vd[0] !== 8'hA5) $display("FAIL read_data: got %h required a5", vd[0]); else passes++;
    checks++; if (vc[0] - acks[0] != 82) $display("FAIL read_latency: got %0d required 82", vc[0] - acks[0]); else passes++;
    checks++; if (dones[0] - acks[0] != 84) $display("FAIL read_done_time: got %0d required 84", dones[0] - acks[0]); else passes++;
    @(negedge clk);
    checks++; if ({spi_csn, busy} !== 2'b10) $display("FAIL read_idle_after: got csn,busy=%b required 10", {spi_csn, busy}); else passes++;
  endtask

  task automatic test_fast();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    hdr = 8 + ADDR_W + DUMMY_CYC; mquad = 0;
    clear_logs();
    issue(24'h0A0B0C, 4'd3, 1'b1, 1'b0);
    wait_dones(1, 300);
    checks++; if (cap !== 32'h0B0A0B0C) $display("FAIL fast_cmd_addr: got %h required 0b0a0b0c", cap); else passes++;
    checks++; if (oe0_lo != 16) $display("FAIL fast_dummy_oe: got %0d cycles required 16", oe0_lo); else passes++;
    checks++; if (vc.size() != 4) $display("FAIL fast_strobes: got %0d required 4", vc.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (vd[i] !== mem[i]) $display("FAIL fast_data%0d: got %h required %h", i, vd[i], mem[i]); else passes++;
    end
    checks++; if (vc[0] - acks[0] != 98) $display("FAIL fast_latency: got %0d required 98", vc[0] - acks[0]); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL fast_busy_drop: got %b required 0", busy); else passes++;
  endtask

`ifdef QSPI_QUAD_EN
  task automatic test_quad();
    mem[0] = 8'hDE; mem[1] = 8'hAD;
    hdr = 8 + ADDR_W + DUMMY_CYC; mquad = 1;
    clear_logs();
    issue(24'h123456, 4'd1, 1'b0, 1'b1);
    wait_dones(1, 200);
    checks++; if (cap !== 32'h6B123456) $display("FAIL quad_cmd_addr: got %h required 6b123456", cap); else passes++;
    checks++; if (vd[0] !== 8'hDE || vd[1] !== 8'hAD) $display("FAIL quad_data: got %h %h required de ad", vd[0], vd[1]); else passes++;
    checks++; if (vc[1] - vc[0] != 4) $display("FAIL quad_spacing: got %0d required 4", vc[1] - vc[0]); else passes++;
    checks++; if (vc[0] - acks[0] != 86) $display("FAIL quad_latency: got %0d required 86", vc[0] - acks[0]); else passes++;
    checks++; if (oe_zero != 24) $display("FAIL quad_oe_release: got %0d cycles required 24", oe_zero); else passes++;
  endtask
`else
  task automatic test_quad_ignored();
    mem[0] = 8'h96; hdr = 32; mquad = 0;
    clear_logs();
    issue(24'h00ABCD, 4'd0, 1'b0, 1'b1);
    wait_dones(1, 200);
    checks++; if (cap !== 32'h0300ABCD) $display("FAIL noquad_cmd: got %h required 0300abcd", cap); else passes++;
    checks++; if (oe0_lo != 0 || oe_zero != 0) $display("FAIL noquad_oe: got %0d/%0d required 0/0", oe0_lo, oe_zero); else passes++;
    checks++; if (vd[0] !== 8'h96) $display("FAIL noquad_data: got %h required 96", vd[0]); else passes++;
  endtask
`endif

  task automatic test_back_to_back();
    int i = 0;
    mem[0] = 8'h3C; hdr = 32; mquad = 0;
    clear_logs();
    @(posedge clk); #2;
    req_addr = 24'h000200; req_len = 4'd0; req_fast = 1'b0; req_quad = 1'b0; req = 1'b1;
    while (acks.size() < 2 && i < 300) begin @(posedge clk); i++; end
    #2 req = 1'b0;
    wait_dones(2, 200);
    checks++; if (acks[1] != dones[0] + 1) $display("FAIL b2b_ack_gap: got ack %0d required %0d", acks[1], dones[0] + 1); else passes++;
    checks++; if (vc.size() != 2 || vd[0] !== 8'h3C || vd[1] !== 8'h3C) $display("FAIL b2b_data: got %0d strobes %h %h required 2 3c 3c", vc.size(), vd[0], vd[1]); else passes++;
    checks++; if (last_hi < 2) $display("FAIL b2b_csn_gap: got %0d required >=2", last_hi); else passes++;
    checks++; if (acks.size() != 2) $display("FAIL b2b_ack_count: got %0d required 2", acks.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    mem[0] = 8'h5A; hdr = 32; mquad = 0;
    clear_logs();
    issue(24'hABCDEF, 4'd0, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({spi_csn, spi_sck, ack, busy, done, rd_valid} !== 6'b100000) $display("FAIL midrst_ctl: got %b required 100000", {spi_csn, spi_sck, ack, busy, done, rd_valid}); else passes++;
    checks++; if (rd_data !== 8'h00 || {io_out, io_oe} !== 8'b1100_1101) $display("FAIL midrst_io: got %h %b required 00 11001101", rd_data, {io_out, io_oe}); else passes++;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    checks++; if (dones.size() != 0 || vc.size() != 0) $display("FAIL midrst_no_done: got %0d dones %0d strobes required 0 0", dones.size(), vc.size()); else passes++;
    clear_logs();
    issue(24'h000777, 4'd0, 1'b0, 1'b0);
    wait_dones(1, 200);
    checks++; if (cap !== 32'h03000777 || vd[0] !== 8'h5A) $display("FAIL midrst_recover: got %h %h required 03000777 5a", cap, vd[0]); else passes++;
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i * 8'h1D);
    hdr = 32; mquad = 0;
    clear_logs();
    issue(24'h345678, 4'd15, 1'b0, 1'b0);
    wait_dones(1, 600);
    checks++; if (vc.size() != 16) $display("FAIL max_strobes: got %0d required 16", vc.size()); else passes++;
    for (int i = 0; i < 16; i++) begin
      checks++; if (vd[i] !== mem[i]) $display("FAIL max_data%0d: got %h required %h", i, vd[i], mem[i]); else passes++;
    end
    checks++; if (sck_tot != 160) $display("FAIL max_sck_edges: got %0d required 160", sck_tot); else passes++;
    checks++; if (dones[0] - vc[15] != 2) $display("FAIL max_done_time: got %0d required 2", dones[0] - vc[15]); else passes++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_fast();
`ifdef QSPI_QUAD_EN
    test_quad();
`else
    test_quad_ignored();
`endif
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
